spi_slave: RTL and testbench

- SPI mode-0 responder (CPOL=0, CPHA=0), MSB first. It is the far end of the team's spi_master.
- Oversamples the external sclk/mosi/ss pins in the local clk domain and deserialises mosi into rx words.
- Serialises a buffered tx word onto miso.
- Exposes a one-word transmit holding register with a valid/ready handshake and a one-cycle rx_valid strobe to local logic.

---
 rtl/spi_slave.sv | 126 ++++++++++++
 tb/tb_spi_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/mosi/ss in the clk domain, deserialises mosi into rx words
// and serialises a one-word holding register onto miso.
module spi_slave #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             tx_underrun
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
    logic                   r_sclk_d, r_ss_d;
    logic [WIDTH-1:0]       r_tx_shift, r_rx_shift, r_hold, r_rx_data;
    logic                   r_hold_full;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_miso, r_oe, r_busy, r_rx_valid, r_underrun;

    logic             w_sclk_s, w_mosi_s, w_sel;
    logic             w_rise, w_fall, w_sel_start, w_last, w_word_start, w_hold_load;
    logic [WIDTH-1:0] w_tx_shift_d, w_rx_shift_d;

    // ss chain resets high so the block comes up deselected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sel        = ~r_ss_sync[SYNC_STAGES-1];
    assign w_rise       = w_sel & w_sclk_s & ~r_sclk_d;
    assign w_fall       = w_sel & ~w_sclk_s & r_sclk_d;
    assign w_sel_start  = w_sel & r_ss_d;
    assign w_last       = w_rise && (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_word_start = w_sel_start | w_last;
    assign w_hold_load  = tx_valid & ~r_hold_full;
    assign w_rx_shift_d = {r_rx_shift[WIDTH-2:0], w_mosi_s};

    // Word start takes the registered holding state; no shift on the fall that opens a word
    always_comb begin
        w_tx_shift_d = r_tx_shift;
        if (!w_sel) begin
            w_tx_shift_d = '0;
        end else if (w_word_start) begin
            w_tx_shift_d = r_hold_full ? r_hold : '0;
        end else if (w_fall && (r_bit_cnt != '0)) begin
            w_tx_shift_d = {r_tx_shift[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_tx_shift <= w_tx_shift_d;
            r_miso     <= w_sel & w_tx_shift_d[WIDTH-1];
            r_oe       <= w_sel;
            r_busy     <= w_sel;
            r_rx_valid <= w_last;
            r_underrun <= w_word_start & ~r_hold_full;

            if (!w_sel) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
            end else if (w_rise) begin
                r_rx_shift <= w_rx_shift_d;
                r_bit_cnt  <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
                if (w_last) begin
                    r_rx_data <= w_rx_shift_d;
                end
            end

            // Load and transfer are exclusive: a load needs an empty register
            if (w_hold_load) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_word_start && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = r_oe;
    assign tx_ready    = ~r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = r_busy;
    assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: directed mode-0 frames, monitors pop expected rx/miso words.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst, sclk, mosi, ss;
    logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, busy, tx_underrun;
    logic [7:0] tx_data, rx_data;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_under = 0;
    int         u0;
    int         tx_bits = 0;
    logic [7:0] tx_word = 8'h00;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];

    always #5 clk = ~clk;

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss         (ss),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // rx monitor: every rx_valid pops one expected word
    always @(negedge clk) begin
        if (tx_underrun === 1'b1) n_under++;
        if (rx_valid === 1'b1) begin
            if (exp_rx_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_unexpected: got rx_valid with 0x%0h expected no strobe", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
            end
        end
    end

    // miso monitor: samples as the master would, on each sclk rise while selected
    always @(posedge sclk or posedge ss) begin
        if (ss === 1'b1) begin
            tx_bits = 0;
        end else begin
            tx_word = {tx_word[6:0], miso};
            tx_bits++;
            if (tx_bits == 8) begin
                tx_bits = 0;
                if (exp_tx_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL miso_unexpected: got word 0x%0h expected none", tx_word);
                end else begin
                    check("miso_word", {24'd0, tx_word}, {24'd0, exp_tx_q.pop_front()});
                end
            end
        end
    end

    task automatic load_tx(input logic [7:0] v);
        int t = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (tx_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL load_tx_timeout: got tx_ready=%b expected 1", tx_ready);
        end
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic sel_on();
        ss = 1'b0;
        #80;
    endtask

    task automatic sel_off();
        #80;
        ss = 1'b1;
        #80;
    endtask

    task automatic spi_bits(input int n, input logic [15:0] w);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = w[i];
            #80 sclk = 1'b1;
            #80 sclk = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", tx_underrun, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: 0xA5 out, 0x3C in
        load_tx(8'hA5);
        check("t1_ready_full", tx_ready, 0);
        exp_tx_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h3C);
        u0 = n_under;
        sel_on();
        check("t1_busy", busy, 1);
        check("t1_oe", miso_oe, 1);
        check("t1_ready_after_xfer", tx_ready, 1);
        spi_bits(8, 16'h003C);
        sel_off();
        check("t1_busy_off", busy, 0);
        check("t1_oe_off", miso_oe, 0);
        check("t1_miso_off", miso, 0);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_underrun", n_under - u0, 1);

        // 4: partial frame then realigned full frame
        u0 = n_under;
        sel_on();
        spi_bits(5, 16'h0016);
        sel_off();
        check("t4_rx_kept", rx_data, 8'h3C);
        load_tx(8'h69);
        exp_tx_q.push_back(8'h69);
        exp_rx_q.push_back(8'h96);
        sel_on();
        spi_bits(8, 16'h0096);
        sel_off();
        check("t4_rx_data", rx_data, 8'h96);
        check("t4_underrun", n_under - u0, 2);

        // 2: back-to-back words, holding refilled with 0x81 during word 1
        load_tx(8'h5A);
        exp_tx_q.push_back(8'h5A);
        exp_tx_q.push_back(8'h81);
        exp_rx_q.push_back(8'h0F);
        exp_rx_q.push_back(8'hF0);
        u0 = n_under;
        sel_on();
        load_tx(8'h81);
        spi_bits(16, 16'h0FF0);
        sel_off();
        check("t2_rx_data", rx_data, 8'hF0);
        check("t2_underrun", n_under - u0, 1);

        // 3: empty holding register at select
        check("t3_ready", tx_ready, 1);
        exp_tx_q.push_back(8'h00);
        exp_rx_q.push_back(8'h55);
        u0 = n_under;
        sel_on();
        check("t3_underrun_start", n_under - u0, 1);
        spi_bits(8, 16'h0055);
        sel_off();
        check("t3_rx_data", rx_data, 8'h55);
        check("t3_underrun", n_under - u0, 2);

        // 5: tx_valid while full is dropped
        load_tx(8'h22);
        @(negedge clk);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        check("t5_ready_full", tx_ready, 0);
        exp_tx_q.push_back(8'h22);
        exp_rx_q.push_back(8'hA5);
        u0 = n_under;
        sel_on();
        spi_bits(8, 16'h00A5);
        sel_off();
        check("t5_ready_empty", tx_ready, 1);
        check("t5_underrun", n_under - u0, 1);

        // 6: async reset mid-word
        load_tx(8'h77);
        sel_on();
        spi_bits(3, 16'h0005);
        #53;
        check("t6_pre_miso", miso, 1);
        check("t6_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_miso", miso, 0);
        check("t6_oe", miso_oe, 0);
        check("t6_busy", busy, 0);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_tx_ready", tx_ready, 1);
        ss   = 1'b1;
        sclk = 1'b0;
        #6;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        load_tx(8'hE7);
        exp_tx_q.push_back(8'hE7);
        exp_rx_q.push_back(8'h18);
        sel_on();
        spi_bits(8, 16'h0018);
        sel_off();
        check("t6_rx_data", rx_data, 8'h18);

        check("rx_queue_empty", exp_rx_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
